reg_file_sb: RTL and testbench

Parametrised multi-read-port integer register file with an integrated per-register busy scoreboard, for the pipelined core. The decode stage reads operands and busy flags and marks destinations busy at issue. Writeback writes results and clears busy. Adds asynchronous reset, a hardwired zero register, write-to-read bypass and hazard tracking.

---
 rtl/reg_file_sb.sv | 115 +++++++++++
 tb/tb_reg_file_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port integer register file with a per-register
// busy scoreboard for the pipelined core.
//
// Decode reads operands and busy flags through NREAD combinational ports and
// marks a destination busy at issue. Writeback writes the result and clears
// the busy flag. Register 0 reads as zero and is never busy.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (clears regs, busy, count)
//   rd_addr   in   NREAD read addresses, port i at [i*AW +: AW]
//   rd_data   out  NREAD read values, port i at [i*XLEN +: XLEN]
//   rd_busy   out  per-port busy flag of the addressed register
//   wr_en     in   writeback valid
//   wr_addr   in   writeback destination
//   wr_data   in   writeback value
//   iss_en    in   issue of an instruction with a destination
//   iss_addr  in   destination being marked busy
//   flush     in   clears every busy flag (pipeline squash)
//   all_idle  out  no register busy
//   busy_cnt  out  number of busy registers
module reg_file_sb #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic                  all_idle,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    // Accesses to register 0 are dropped everywhere.
    logic wr_act;
    logic iss_act;
    assign wr_act  = wr_en  && (wr_addr  != '0);
    assign iss_act = iss_en && (iss_addr != '0);

    logic inc;
    logic dec;

    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;
        inc        = 1'b0;
        dec        = 1'b0;
        if (flush) begin
            // A same-cycle issue is squashed along with everything else.
            busy_d     = '0;
            busy_cnt_d = '0;
        end else begin
            // Clear first, then set: on a same-register collision the new
            // producer owns the register, so it stays busy.
            if (wr_act) busy_d[wr_addr] = 1'b0;
            if (iss_act) busy_d[iss_addr] = 1'b1;
            // Count only real 0->1 and 1->0 transitions of the flags.
            inc = iss_act && !busy_q[iss_addr];
            dec = wr_act && busy_q[wr_addr] &&
                  !(iss_act && (iss_addr == wr_addr));
            busy_cnt_d = busy_cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_act) begin
            // Writes commit even under flush.
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign all_idle = (busy_cnt_q == '0);

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        assign ra  = rd_addr[g*AW +: AW];
        // A same-cycle writeback to the addressed register supplies both the
        // fresh value and a cleared busy flag.
        assign hit = (BYPASS != 0) && wr_act && (wr_addr == ra);
        assign rd_data[g*XLEN +: XLEN] = (ra == '0) ? '0 :
                                         hit ? wr_data : regs_q[ra];
        assign rd_busy[g] = hit ? 1'b0 : busy_q[ra];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [NREAD*AW-1:0]   rd_addr;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic                  flush;

    logic [NREAD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NREAD-1:0]      rd_busy_b, rd_busy_n;
    logic                  all_idle_b, all_idle_n;
    logic [AW:0]           busy_cnt_b, busy_cnt_n;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .all_idle(all_idle_b), .busy_cnt(busy_cnt_b)
    );

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .all_idle(all_idle_n), .busy_cnt(busy_cnt_n)
    );

    // Reference model: plain arrays of register values and busy flags.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int p, input bit byp);
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        if (a == 0) return '0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int p, input bit byp);
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        if (a == 0) return 1'b0;
        if (byp && wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_all();
        for (int p = 0; p < NREAD; p++) begin
            chk($sformatf("byp_data%0d", p), 64'(rd_data_b[p*XLEN +: XLEN]), 64'(exp_data(p, 1'b1)));
            chk($sformatf("nob_data%0d", p), 64'(rd_data_n[p*XLEN +: XLEN]), 64'(exp_data(p, 1'b0)));
            chk($sformatf("byp_busy%0d", p), 64'(rd_busy_b[p]), 64'(exp_busy(p, 1'b1)));
            chk($sformatf("nob_busy%0d", p), 64'(rd_busy_n[p]), 64'(exp_busy(p, 1'b0)));
        end
        chk("byp_cnt", 64'(busy_cnt_b), 64'(m_count()));
        chk("nob_cnt", 64'(busy_cnt_n), 64'(m_count()));
        chk("byp_idle", 64'(all_idle_b), 64'(m_count() == 0));
        chk("nob_idle", 64'(all_idle_n), 64'(m_count() == 0));
    endtask

    task automatic model_update();
        if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        end else begin
            if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    // Entered just after a rising edge with inputs already applied.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    task automatic do_wr(input int a, input logic [XLEN-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    endtask

    task automatic do_iss(input int a);
        iss_en = 1'b1; iss_addr = AW'(a);
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        idle();
        set_rd(5, 9);
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write x5, issue x6, then reset asynchronously mid-cycle.
        do_wr(5, 64'hDEAD); do_iss(6); set_rd(5, 6);
        cyc();
        idle();
        #1;
        chk("pre_rst_x5", 64'(rd_data_b[0 +: XLEN]), 64'hDEAD);
        chk("pre_rst_cnt", 64'(busy_cnt_b), 64'd1);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_x5", 64'(rd_data_b[0 +: XLEN]), 64'd0);
        chk("rst_x6_busy", 64'(rd_busy_b[1]), 64'd0);
        chk("rst_idle", 64'(all_idle_b), 64'd1);
        chk("rst_cnt", 64'(busy_cnt_n), 64'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_update();
        #1;

        // Zero register.
        do_wr(0, '1); do_iss(0); set_rd(0, 0);
        cyc();
        idle();
        #1;
        chk("x0_data", 64'(rd_data_b[0 +: XLEN]), 64'd0);
        chk("x0_busy", 64'(rd_busy_b[0]), 64'd0);
        chk("x0_cnt", 64'(busy_cnt_b), 64'd0);
        cyc();

        // Bypass versus no bypass.
        do_wr(7, 64'h1234); set_rd(7, 7);
        #1;
        chk("byp_x7_same", 64'(rd_data_b[0 +: XLEN]), 64'h1234);
        chk("nob_x7_same", 64'(rd_data_n[0 +: XLEN]), 64'h0);
        chk("byp_x7_busy", 64'(rd_busy_b[0]), 64'd0);
        cyc();
        idle();
        #1;
        chk("nob_x7_next", 64'(rd_data_n[0 +: XLEN]), 64'h1234);
        cyc();

        // Scoreboard sequence.
        set_rd(3, 4);
        do_iss(3); cyc(); idle(); #1;
        chk("sb_cnt1", 64'(busy_cnt_b), 64'd1);
        chk("sb_x3_busy", 64'(rd_busy_n[0]), 64'd1);
        do_iss(4); cyc(); idle(); #1;
        chk("sb_cnt2", 64'(busy_cnt_b), 64'd2);
        do_wr(3, 64'h33); cyc(); idle(); #1;
        chk("sb_cnt_wb3", 64'(busy_cnt_b), 64'd1);
        do_iss(4); cyc(); idle(); #1;
        chk("sb_cnt_reiss4", 64'(busy_cnt_n), 64'd1);
        do_wr(4, 64'h44); cyc(); idle(); #1;
        chk("sb_idle", 64'(all_idle_b), 64'd1);
        cyc();

        // Collision on a busy register.
        set_rd(9, 9);
        do_iss(9); cyc(); idle(); #1;
        chk("col_cnt_before", 64'(busy_cnt_b), 64'd1);
        do_iss(9); do_wr(9, 64'hABC); cyc(); idle(); #1;
        chk("col_data", 64'(rd_data_n[0 +: XLEN]), 64'hABC);
        chk("col_busy", 64'(rd_busy_b[0]), 64'd1);
        chk("col_cnt", 64'(busy_cnt_b), 64'd1);
        cyc();

        // Flush with five busy registers plus same-cycle issue and write.
        for (int r = 12; r < 16; r++) begin
            do_iss(r); cyc(); idle();
        end
        #1;
        chk("fl_cnt_before", 64'(busy_cnt_b), 64'd5);
        set_rd(10, 11);
        flush = 1'b1; do_iss(10); do_wr(11, 64'h55);
        cyc();
        idle();
        #1;
        chk("fl_cnt", 64'(busy_cnt_b), 64'd0);
        chk("fl_x10_busy", 64'(rd_busy_n[0]), 64'd0);
        chk("fl_x11_data", 64'(rd_data_n[AW > 0 ? XLEN : 0 +: XLEN]), 64'h55);
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, 15));
            wr_data  = {$urandom, $urandom};
            iss_en   = ($urandom_range(0, 9) < 6);
            iss_addr = AW'($urandom_range(0, 15));
            flush    = ($urandom_range(0, 24) == 0);
            set_rd($urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rd_addr[0 +: AW] = wr_addr;
            if ($urandom_range(0, 3) == 0) rd_addr[AW +: AW] = iss_addr;
            cyc();
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
